// File: rtl/scan_fsm_pkg.sv
// Shared types and helpers for the full-scan modulo up/down counter.
// Chain geometry and terminal-count detection are kept here so the top stays structural.
package scan_fsm_pkg;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

    // Number of scan-vector bits that land in chain k (bits i with i % nchains == k).
    function automatic int chain_len(input int width, input int nchains, input int k);
        return (width + 1 - k + nchains - 1) / nchains;
    endfunction

    // Index of the last (highest) scan-vector bit in chain k; this bit drives SDO[k].
    function automatic int chain_tail(input int width, input int nchains, input int k);
        return k + (chain_len(width, nchains, k) - 1) * nchains;
    endfunction

    // True when a count step from q in direction c wraps around the modulus.
    function automatic logic is_term(input int unsigned q, input dir_t c, input int unsigned mod);
        logic term;
        case (c)
            UP:      term = (q == (mod - 32'd1));
            DOWN:    term = (q == 32'd0);
            default: term = 1'b0;
        endcase
        return term;
    endfunction

endpackage

// File: rtl/scan_reg.sv
// W-bit flop vector with synchronous active-high reset and a per-bit functional/scan input mux.
module scan_reg #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         mode_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] scan_in_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Select shift data in scan mode, functional next-state otherwise.
    always_comb begin
        q_d = d_i;
        if (mode_i) begin
            q_d = scan_in_i;
        end else begin
            q_d = d_i;
        end
    end

    // State flops; reset wins over both functional and scan updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/scan_counter_fsm.sv
// Full-scan modulo up/down counter with registered terminal-count flag and NCHAINS parallel scan chains.
// Optional macro SCAN_SDO_GATE_EN: forces SDO to zero while m=0.
module scan_counter_fsm
    import scan_fsm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MOD     = 10,
    parameter int NCHAINS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               c,
    input  logic               m,
    input  logic [NCHAINS-1:0] SDI,
    output logic [WIDTH-1:0]   q,
    output logic               n,
    output logic [NCHAINS-1:0] SDO
);

    localparam int               VW      = WIDTH + 1;
    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);

    if (WIDTH < $clog2(MOD)) begin : g_chk_width
        $error("scan_counter_fsm: WIDTH too small for MOD");
    end
    if (MOD < 2) begin : g_chk_mod
        $error("scan_counter_fsm: MOD must be at least 2");
    end
    if ((NCHAINS < 1) || (NCHAINS > VW)) begin : g_chk_chains
        $error("scan_counter_fsm: NCHAINS must lie in 1..WIDTH+1");
    end

    logic [VW-1:0]      v_q;
    logic [VW-1:0]      v_d;
    logic [VW-1:0]      scan_in_s;
    logic [WIDTH-1:0]   cnt_s;
    logic [WIDTH-1:0]   cnt_d;
    logic               term_d;
    logic [NCHAINS-1:0] tails_s;
    dir_t               dir_s;

    assign cnt_s = v_q[WIDTH-1:0];
    assign dir_s = dir_t'(c);

    // Functional next state: explicit-compare wrap; illegal states recover to zero with no flag.
    always_comb begin
        cnt_d  = cnt_s;
        term_d = v_q[WIDTH];
        if (a) begin
            term_d = is_term(32'(cnt_s), dir_s, 32'(MOD));
            if (cnt_s > MOD_MAX) begin
                cnt_d = ZERO;
            end else begin
                case (dir_s)
                    UP:      cnt_d = (cnt_s == MOD_MAX) ? ZERO : (cnt_s + ONE);
                    DOWN:    cnt_d = (cnt_s == ZERO) ? MOD_MAX : (cnt_s - ONE);
                    default: cnt_d = ZERO;
                endcase
            end
        end else begin
            cnt_d  = cnt_s;
            term_d = v_q[WIDTH];
        end
    end

    assign v_d = {term_d, cnt_d};

    // Each bit takes its chain predecessor NCHAINS positions below; chain heads take SDI.
    for (genvar i = 0; i < VW; i++) begin : g_scan_in
        if (i >= NCHAINS) begin : g_link
            assign scan_in_s[i] = v_q[i-NCHAINS];
        end else begin : g_head
            assign scan_in_s[i] = SDI[i];
        end
    end

    for (genvar k = 0; k < NCHAINS; k++) begin : g_tail
        localparam int TAIL = chain_tail(WIDTH, NCHAINS, k);
        assign tails_s[k] = v_q[TAIL];
    end

    scan_reg #(
        .W (VW)
    ) u_scan_reg (
        .clk_i     (clk),
        .rst_i     (rst),
        .mode_i    (m),
        .d_i       (v_d),
        .scan_in_i (scan_in_s),
        .q_o       (v_q)
    );

    assign q = v_q[WIDTH-1:0];
    assign n = v_q[WIDTH];

`ifdef SCAN_SDO_GATE_EN
    assign SDO = m ? tails_s : {NCHAINS{1'b0}};
`else
    assign SDO = tails_s;
`endif

endmodule

// File: tb/tb_scan_counter_fsm.sv
// Scoreboard bench for scan_counter_fsm: directed scenarios then random stimulus against a queue-based chain model.
module tb_scan_counter_fsm;

    localparam int WIDTH   = 4;
    localparam int MOD     = 10;
    localparam int NCHAINS = 2;
    localparam int VW      = WIDTH + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               a   = 1'b0;
    logic               c   = 1'b0;
    logic               m   = 1'b0;
    logic [NCHAINS-1:0] sdi = '0;
    logic [WIDTH-1:0]   q;
    logic               n;
    logic [NCHAINS-1:0] sdo;
    logic [NCHAINS-1:0] pre_sdo;

    typedef struct {
        int                 cyc;
        int                 q;
        bit                 n;
        bit [NCHAINS-1:0]   sdo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference state: integer count plus flag.
    int   mq = 0;
    bit   mn = 1'b0;

    always #5 clk = ~clk;

    scan_counter_fsm #(
        .WIDTH   (WIDTH),
        .MOD     (MOD),
        .NCHAINS (NCHAINS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .c   (c),
        .m   (m),
        .SDI (sdi),
        .q   (q),
        .n   (n),
        .SDO (sdo)
    );

    function automatic bit [VW-1:0] model_vec();
        bit [VW-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = ((mq >> i) & 1) != 0;
        v[WIDTH] = mn;
        return v;
    endfunction

    function automatic bit [NCHAINS-1:0] model_sdo(bit mm);
        bit [VW-1:0]      v;
        bit [NCHAINS-1:0] s;
        int               last;
        v = model_vec();
        for (int k = 0; k < NCHAINS; k++) begin
            last = k;
            while (last + NCHAINS <= WIDTH) last += NCHAINS;
            s[k] = v[last];
        end
`ifdef SCAN_SDO_GATE_EN
        if (!mm) s = '0;
`endif
        return s;
    endfunction

    task automatic model_step();
        bit [VW-1:0] v;
        bit          ch[$];
        int          j;
        if (rst) begin
            mq = 0;
            mn = 1'b0;
        end else if (m) begin
            v = model_vec();
            for (int k = 0; k < NCHAINS; k++) begin
                ch.delete();
                for (int i = k; i < VW; i += NCHAINS) ch.push_back(v[i]);
                ch.push_front(sdi[k]);
                void'(ch.pop_back());
                j = 0;
                for (int i = k; i < VW; i += NCHAINS) begin
                    v[i] = ch[j];
                    j++;
                end
            end
            mq = 0;
            for (int i = 0; i < WIDTH; i++) if (v[i]) mq += (1 << i);
            mn = v[WIDTH];
        end else if (a) begin
            if (mq >= MOD) begin
                mq = 0;
                mn = 1'b0;
            end else if (c) begin
                mn = (mq == MOD - 1);
                mq = (mq + 1) % MOD;
            end else begin
                mn = (mq == 0);
                mq = (mq + MOD - 1) % MOD;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, capture pre-edge SDO, push the post-edge expectation.
    task automatic cycle(input bit r, input bit aa, input bit cc, input bit mm, input bit [NCHAINS-1:0] s);
        exp_t e;
        @(negedge clk);
        rst = r; a = aa; c = cc; m = mm; sdi = s;
        #1;
        pre_sdo = sdo;
        model_step();
        e.cyc = cyc;
        e.q   = mq;
        e.n   = mn;
        e.sdo = model_sdo(mm);
        sb.push_back(e);
        cyc++;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge with an outstanding expectation is compared after outputs settle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== WIDTH'(e.q) || n !== e.n || sdo !== e.sdo) begin
                    failures++;
                    $display("FAIL sb cyc%0d: got q=%0d n=%0b sdo=%b expected q=%0d n=%0b sdo=%b",
                             e.cyc, q, n, sdo, e.q, e.n, e.sdo);
                end
            end
        end
    end

    initial begin
        bit [NCHAINS-1:0] sdo_seq [3];
        sdo_seq[0] = 2'b10;
        sdo_seq[1] = 2'b00;
        sdo_seq[2] = 2'b01;

        // Reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("reset_q", int'(q), 0);
        chk("reset_n", int'(n), 0);
        chk("reset_sdo", int'(sdo), 0);

        // Full up sweep: wrap on the tenth edge raises n
        for (int i = 0; i < MOD; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("up_wrap_q", int'(q), 0);
        chk("up_wrap_n", int'(n), 1);

        // Down wrap then hold
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("down_wrap_q", int'(q), 9);
        chk("down_wrap_n", int'(n), 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("hold_q", int'(q), 9);
        chk("hold_n", int'(n), 1);

        // Scan load of illegal 11, then recovery
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("scan_load_q", int'(q), 11);
        chk("scan_load_n", int'(n), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("illegal_recover_q", int'(q), 0);
        chk("illegal_recover_n", int'(n), 0);

        // Reach q=9 with n=0, then unload
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("preunload_q", int'(q), 9);
        chk("preunload_n", int'(n), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
            chk($sformatf("unload_sdo%0d", i), int'(pre_sdo), int'(sdo_seq[i]));
        end

        // Reset in the middle of a load
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("rst_midshift_q", int'(q), 0);
        chk("rst_midshift_n", int'(n), 0);

        // Load all ones, then observe SDO in functional mode
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
`ifdef SCAN_SDO_GATE_EN
        chk("sdo_gated", int'(sdo), 0);
`else
        chk("sdo_ungated", int'(sdo), 3);
`endif

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), NCHAINS'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
